// File: rtl/cla_adder_pipe.sv
// Pipelined WIDTH-bit carry-lookahead add/sub built from GROUP-bit lookahead groups; latency STAGES cycles.
// Backpressure: all ranks advance together only when the output rank is empty or being taken (in_ready = adv).
module cla_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NGRP = WIDTH / GROUP;
    localparam int GPS  = NGRP / STAGES;
    localparam int SW   = GPS * GROUP;

    logic adv;
    logic ovf_q;
    logic zero_q;

    // Resolves one stage's slice: per-bit carries inside each group, group P*/G* carry between groups.
    function automatic logic [SW:0] cla_slice(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                              input logic cin);
        logic [SW-1:0] p;
        logic [SW-1:0] g;
        logic [SW-1:0] c;
        logic          gcy;
        logic          pg;
        logic          gg;
        logic          cc;
        p   = a | b;
        g   = a & b;
        c   = '0;
        gcy = cin;
        for (int k = 0; k < GPS; k++) begin
            pg = 1'b1;
            gg = 1'b0;
            cc = gcy;
            for (int j = 0; j < GROUP; j++) begin
                c[k*GROUP+j] = cc;
                cc = g[k*GROUP+j] | (p[k*GROUP+j] & cc);
                gg = g[k*GROUP+j] | (p[k*GROUP+j] & gg);
                pg = pg & p[k*GROUP+j];
            end
            gcy = gg | (pg & gcy);
        end
        return {gcy, a ^ b ^ c};
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign ovf      = ovf_q;
    assign zero     = zero_q;

    for (genvar s = 0; s < STAGES; s++) begin : g_stg
        localparam int LO = s * SW;
        localparam int HI = LO + SW;

        logic              v_i;
        logic              c_i;
        logic [WIDTH-1:LO] a_i;
        logic [WIDTH-1:LO] bx_i;
        logic [SW-1:0]     grp_sum;
        logic [HI-1:0]     sum_d;
        logic [HI-1:0]     sum_q;
        logic              c_d;
        logic              c_q;
        logic              vld_d;
        logic              vld_q;

        // Subtract is folded in at entry: B inverted and carry forced, so later ranks only see B'.
        if (s == 0) begin : g_src
            assign v_i   = in_valid;
            assign c_i   = sub | Cin;
            assign a_i   = A;
            assign bx_i  = sub ? ~B : B;
            assign sum_d = grp_sum;
        end else begin : g_src
            assign v_i   = g_stg[s-1].vld_q;
            assign c_i   = g_stg[s-1].c_q;
            assign a_i   = g_stg[s-1].g_fwd.a_q;
            assign bx_i  = g_stg[s-1].g_fwd.bx_q;
            assign sum_d = {grp_sum, g_stg[s-1].sum_q};
        end

        always_comb begin
            {c_d, grp_sum} = cla_slice(a_i[HI-1:LO], bx_i[HI-1:LO], c_i);
            vld_d          = v_i;
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                c_q   <= 1'b0;
                sum_q <= '0;
            end else if (adv) begin
                vld_q <= vld_d;
                if (vld_d) begin
                    c_q   <= c_d;
                    sum_q <= sum_d;
                end
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [WIDTH-1:HI] a_d;
            logic [WIDTH-1:HI] bx_d;
            logic [WIDTH-1:HI] a_q;
            logic [WIDTH-1:HI] bx_q;

            always_comb begin
                a_d  = a_i[WIDTH-1:HI];
                bx_d = bx_i[WIDTH-1:HI];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q  <= '0;
                    bx_q <= '0;
                end else if (adv && vld_d) begin
                    a_q  <= a_d;
                    bx_q <= bx_d;
                end
            end
        end else begin : g_out
            logic ovf_d;
            logic zero_d;

            // Carry into the MSB is recovered from its sum bit: c[W-1] = a ^ b' ^ sum.
            always_comb begin
                ovf_d  = c_d ^ a_i[WIDTH-1] ^ bx_i[WIDTH-1] ^ sum_d[WIDTH-1];
                zero_d = (sum_d == '0);
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (adv && vld_d) begin
                    ovf_q  <= ovf_d;
                    zero_q <= zero_d;
                end
            end

            assign out_valid = vld_q;
            assign F         = sum_q;
            assign Cout      = c_q;
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Directed vector table, stall/flush sequences and a randomized scoreboard run for cla_adder_pipe.
module tb_cla_adder_pipe;
    localparam int W   = 16;
    localparam int STG = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         Cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] F;
    logic         Cout;
    logic         ovf;
    logic         zero;

    int checks   = 0;
    int failures = 0;

    cla_adder_pipe #(.WIDTH(W), .GROUP(4), .STAGES(STG)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .F(F), .Cout(Cout), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sb;
        logic [15:0] f;
        logic        cout;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t        vecs[15];
    logic [18:0] q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer sum of A + B' + cin; returns {zero, ovf, cout, f}.
    function automatic logic [18:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic ci, input logic s);
        logic [W-1:0] bx;
        logic [W:0]   ext;
        logic         o;
        bx  = s ? ~b : b;
        ext = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, (s ? 1'b1 : ci)};
        o   = (a[W-1] == bx[W-1]) && (ext[W-1] != a[W-1]);
        return {(ext[W-1:0] == '0), o, ext[W], ext[W-1:0]};
    endfunction

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic s);
        A        = a;
        B        = b;
        Cin      = ci;
        sub      = s;
        in_valid = 1'b1;
    endtask

    initial begin
        int          lat;
        int          n;
        int          last;
        logic        acc;
        logic        obs;
        logic        hold;
        logic        seen;
        logic [18:0] prev;
        logic [18:0] t4[3];
        logic [18:0] got;

        vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1};
        vecs[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{16'h0003, 16'h0003, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        A         = '0;
        B         = '0;
        Cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_f", F, 0);
        check("rst_flags", {Cout, ovf, zero}, 0);
        check("rst_in_ready", in_ready, 1);

        // Directed table, one operation at a time.
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sb);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            wait_out(lat);
            check($sformatf("v%0d_latency", i), lat, STG);
            check($sformatf("v%0d_f", i), F, vecs[i].f);
            check($sformatf("v%0d_cout", i), Cout, vecs[i].cout);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
            check($sformatf("v%0d_zero", i), zero, vecs[i].z);
            @(posedge clk);
        end

        // Three back-to-back ops against a stalled consumer, then release.
        @(negedge clk);
        out_ready = 1'b0;
        t4[0] = model(16'h1111, 16'h2222, 1'b0, 1'b0);
        t4[1] = model(16'h9000, 16'h1000, 1'b0, 1'b1);
        t4[2] = model(16'h00FF, 16'hFF01, 1'b0, 1'b0);
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(16'h9000, 16'h1000, 1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        drive(16'h00FF, 16'hFF01, 1'b0, 1'b0);
        #1;
        check("t4_in_ready_full", in_ready, 0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("t4_hold%0d", k), {out_valid, zero, ovf, Cout, F}, {1'b1, t4[0]});
            check($sformatf("t4_hold_rdy%0d", k), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        n    = 0;
        last = -1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            acc = in_valid && in_ready;
            if (out_valid) begin
                if (n < 3) check($sformatf("t4_order%0d", n), {zero, ovf, Cout, F}, t4[n]);
                n++;
                last = cyc;
            end
            @(posedge clk);
            @(negedge clk);
            if (acc) in_valid = 1'b0;
            #1;
        end
        check("t4_count", n, 3);
        check("t4_last_cycle", last, 2);

        // Flush: one op accepted, reset on the following edge while another is offered.
        @(negedge clk);
        drive(16'h4000, 16'h4000, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        seen = out_valid;
        drive(16'h0001, 16'h0002, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("t5_rst_f", F, 0);
        check("t5_rst_flags", {Cout, ovf, zero}, 0);
        for (int k = 0; k < 4; k++) begin
            if (out_valid) seen = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        check("t5_flushed", seen, 0);
        drive(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_out(lat);
        check("t5_post_latency", lat, STG);
        check("t5_post_result", {zero, ovf, Cout, F}, {3'b000, 16'h1000});
        @(posedge clk);

        // Randomized traffic with random backpressure against the integer model.
        hold = 1'b0;
        prev = '0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            A         = (i % 7 == 0) ? 16'hFFFF : W'($urandom);
            B         = (i % 5 == 0) ? 16'h8000 : W'($urandom);
            Cin       = $urandom_range(0, 1) == 1;
            sub       = $urandom_range(0, 1) == 1;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (hold) check("rnd_hold", {out_valid, zero, ovf, Cout, F}, {1'b1, prev});
            acc = in_valid && in_ready;
            obs = out_valid && out_ready;
            if (acc) q.push_back(model(A, B, Cin, sub));
            if (obs) begin
                if (q.size() == 0) begin
                    check("rnd_extra_output", 1, 0);
                end else begin
                    got = q.pop_front();
                    check("rnd_result", {zero, ovf, Cout, F}, got);
                end
            end
            hold = out_valid && !out_ready;
            prev = {zero, ovf, Cout, F};
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (out_valid) begin
                if (q.size() == 0) begin
                    check("rnd_extra_drain", 1, 0);
                end else begin
                    got = q.pop_front();
                    check("rnd_drain_result", {zero, ovf, Cout, F}, got);
                end
            end
            @(negedge clk);
        end
        check("rnd_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
